// File: rtl/mem_bus_arbiter.sv
`timescale 1ns/1ps
// mem_bus_arbiter: shares one SRAM-like bus between the fetch and data ports,
// one outstanding transaction at a time, alternating grants under contention.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                resetn,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    output logic                inst_done,
    output logic                imem_busy,

    input  logic                data_req,
    input  logic                data_wr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wstrb,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                data_done,
    output logic                dmem_busy,

    output logic                bus_req,
    output logic                bus_wr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W/8-1:0] bus_wstrb,
    output logic [DATA_W-1:0]   bus_wdata,
    input  logic                bus_addr_ok,
    input  logic                bus_data_ok,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                grant_data;
    logic                in_addr;
    logic                in_done;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        grant_data   = 1'b0;

        case (state_q)
            IDLE: begin
                if (inst_req || data_req) begin
                    // Under contention the port opposite to the last winner goes next.
                    grant_data   = data_req && (!inst_req || !last_grant_q);
                    owner_d      = grant_data;
                    last_grant_d = grant_data;
                    wr_d         = grant_data ? data_wr : 1'b0;
                    addr_d       = grant_data ? data_addr : inst_addr;
                    wstrb_d      = grant_data ? data_wstrb : {STRB_W{1'b1}};
                    wdata_d      = grant_data ? data_wdata : '0;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (bus_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus_data_ok) begin
                    rdata_d = bus_rdata;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_addr = (state_q == ADDR);
    assign in_done = (state_q == DONE);

    assign bus_req   = in_addr;
    assign bus_wr    = in_addr & wr_q;
    assign bus_addr  = in_addr ? addr_q  : '0;
    assign bus_wstrb = in_addr ? wstrb_q : '0;
    assign bus_wdata = in_addr ? wdata_q : '0;

    assign inst_done  = in_done & ~owner_q;
    assign data_done  = in_done &  owner_q;
    assign inst_rdata = inst_done ? rdata_q : '0;
    assign data_rdata = data_done ? rdata_q : '0;

    assign imem_busy = inst_req & ~inst_done;
    assign dmem_busy = data_req & ~data_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
`timescale 1ns/1ps
// Directed bench for mem_bus_arbiter: per-scenario tasks, a per-cycle log of
// DUT outputs, and a bus responder with programmable wait states.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        inst_done;
    logic        imem_busy;
    logic        data_req = 1'b0;
    logic        data_wr = 1'b0;
    logic [31:0] data_addr = '0;
    logic [3:0]  data_wstrb = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        data_done;
    logic        dmem_busy;
    logic        bus_req;
    logic        bus_wr;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    int tests_run = 0;
    int tests_failed = 0;

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .inst_done(inst_done), .imem_busy(imem_busy),
        .data_req(data_req), .data_wr(data_wr), .data_addr(data_addr),
        .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_done(data_done), .dmem_busy(dmem_busy),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr),
        .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    // Bus handshake source: reactive responder or manual per-cycle driving.
    logic        resp_en = 1'b0;
    int          addr_wait = 0;
    int          data_wait = 0;
    logic [31:0] resp_rdata = '0;
    logic        rsp_addr_ok = 1'b0, rsp_data_ok = 1'b0;
    logic        man_addr_ok = 1'b0, man_data_ok = 1'b0;
    logic [31:0] man_rdata = '0;
    int          a_cnt = 0, d_cnt = 0;
    logic        d_pend = 1'b0;

    assign bus_addr_ok = resp_en ? rsp_addr_ok : man_addr_ok;
    assign bus_data_ok = resp_en ? rsp_data_ok : man_data_ok;
    assign bus_rdata   = resp_en ? resp_rdata  : man_rdata;

    // data_wait counts DATA-phase cycles before data_ok; addr_wait counts ADDR cycles.
    always @(negedge clk or negedge resetn) begin
        if (!resetn || !resp_en) begin
            a_cnt = 0; d_cnt = 0; d_pend = 1'b0;
            rsp_addr_ok = 1'b0; rsp_data_ok = 1'b0;
        end else begin
            rsp_addr_ok = 1'b0;
            rsp_data_ok = 1'b0;
            if (bus_req) begin
                if (a_cnt >= addr_wait) begin
                    rsp_addr_ok = 1'b1; a_cnt = 0; d_pend = 1'b1; d_cnt = 0;
                end else a_cnt++;
            end else if (d_pend) begin
                if (d_cnt >= data_wait) begin
                    rsp_data_ok = 1'b1; d_pend = 1'b0;
                end else d_cnt++;
            end
        end
    end

    localparam int LOG_N = 2048;
    int          cyc = 0;
    logic        lg_breq  [LOG_N];
    logic        lg_bwr   [LOG_N];
    logic [31:0] lg_baddr [LOG_N];
    logic [3:0]  lg_bstrb [LOG_N];
    logic [31:0] lg_bwdat [LOG_N];
    logic        lg_idone [LOG_N];
    logic        lg_ddone [LOG_N];
    logic [31:0] lg_irdat [LOG_N];
    logic [31:0] lg_drdat [LOG_N];
    logic        lg_ibusy [LOG_N];
    logic        lg_dbusy [LOG_N];

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            lg_breq[cyc]  = bus_req;   lg_bwr[cyc]   = bus_wr;
            lg_baddr[cyc] = bus_addr;  lg_bstrb[cyc] = bus_wstrb;
            lg_bwdat[cyc] = bus_wdata; lg_idone[cyc] = inst_done;
            lg_ddone[cyc] = data_done; lg_irdat[cyc] = inst_rdata;
            lg_drdat[cyc] = data_rdata; lg_ibusy[cyc] = imem_busy;
            lg_dbusy[cyc] = dmem_busy;
        end
        cyc++;
    end

    task automatic do_reset();
        resetn = 1'b0;
        inst_req = 1'b0; inst_addr = '0;
        data_req = 1'b0; data_wr = 1'b0; data_addr = '0; data_wstrb = '0; data_wdata = '0;
        man_addr_ok = 1'b0; man_data_ok = 1'b0; man_rdata = '0;
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1;
    endtask

    task automatic wait_done(input logic want_data, input int limit, output logic seen);
        seen = 1'b0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk); #1;
            if ((want_data && data_done) || (!want_data && inst_done)) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        resp_en = 1'b0;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if ({bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata} !== 70'd0) begin
            tests_failed++;
            $display("FAIL reset_bus: got req=%b wr=%b addr=%h strb=%h wdata=%h want all 0",
                     bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata);
        end
        tests_run++;
        if ({inst_done, data_done, inst_rdata, data_rdata} !== 66'd0) begin
            tests_failed++;
            $display("FAIL reset_done: got idone=%b ddone=%b irdata=%h drdata=%h want all 0",
                     inst_done, data_done, inst_rdata, data_rdata);
        end
        tests_run++;
        if ({imem_busy, dmem_busy} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_busy_idle: got %b%b want 00", imem_busy, dmem_busy);
        end
        inst_req = 1'b1; #1;
        tests_run++;
        if ({imem_busy, dmem_busy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_busy_inst: got %b%b want 10", imem_busy, dmem_busy);
        end
        data_req = 1'b1; #1;
        tests_run++;
        if ({imem_busy, dmem_busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL reset_busy_both: got %b%b want 11", imem_busy, dmem_busy);
        end
        inst_req = 1'b0; data_req = 1'b0;
        do_reset();
    endtask

    task automatic test_single_fetch();
        int   c1;
        logic seen;
        logic exp_b;
        do_reset();
        resp_en = 1'b1; addr_wait = 0; data_wait = 0; resp_rdata = 32'h3C1D0001;
        inst_addr = 32'hBFC00000; inst_req = 1'b1; c1 = cyc;
        wait_done(1'b0, 20, seen);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL fetch_timeout: got no inst_done want one"); end
        @(posedge clk); #2 inst_req = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            exp_b = (k == 1);
            tests_run++;
            if (lg_breq[c1+k] !== exp_b) begin
                tests_failed++;
                $display("FAIL fetch_bus_req c%0d: got %b want %b", k+1, lg_breq[c1+k], exp_b);
            end
            exp_b = (k == 3);
            tests_run++;
            if (lg_idone[c1+k] !== exp_b || lg_ddone[c1+k] !== 1'b0) begin
                tests_failed++;
                $display("FAIL fetch_done c%0d: got i=%b d=%b want i=%b d=0",
                         k+1, lg_idone[c1+k], lg_ddone[c1+k], exp_b);
            end
            exp_b = (k < 3);
            tests_run++;
            if (lg_ibusy[c1+k] !== exp_b) begin
                tests_failed++;
                $display("FAIL fetch_busy c%0d: got %b want %b", k+1, lg_ibusy[c1+k], exp_b);
            end
            tests_run++;
            if (lg_irdat[c1+k] !== ((k == 3) ? 32'h3C1D0001 : 32'h0)) begin
                tests_failed++;
                $display("FAIL fetch_rdata c%0d: got %h", k+1, lg_irdat[c1+k]);
            end
        end
        tests_run++;
        if (lg_baddr[c1+1] !== 32'hBFC00000 || lg_bstrb[c1+1] !== 4'hF || lg_bwr[c1+1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL fetch_bus_fields: got addr=%h strb=%h wr=%b want BFC00000 F 0",
                     lg_baddr[c1+1], lg_bstrb[c1+1], lg_bwr[c1+1]);
        end
    endtask

    task automatic test_simultaneous();
        int   c1;
        logic seen;
        do_reset();
        resp_en = 1'b1; addr_wait = 0; data_wait = 0; resp_rdata = 32'h12345678;
        inst_addr = 32'h1FC00040;
        data_wr = 1'b1; data_addr = 32'h80001000; data_wstrb = 4'h3; data_wdata = 32'h0000BEEF;
        inst_req = 1'b1; data_req = 1'b1; c1 = cyc;
        wait_done(1'b1, 20, seen);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL simul_data_timeout: got no data_done want one"); end
        @(posedge clk); #2 data_req = 1'b0; data_wr = 1'b0;
        wait_done(1'b0, 20, seen);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL simul_inst_timeout: got no inst_done want one"); end
        @(posedge clk); #2 inst_req = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (lg_breq[c1+1] !== 1'b1 || lg_bwr[c1+1] !== 1'b1 || lg_baddr[c1+1] !== 32'h80001000 ||
            lg_bstrb[c1+1] !== 4'h3 || lg_bwdat[c1+1] !== 32'h0000BEEF) begin
            tests_failed++;
            $display("FAIL simul_first_store: got req=%b wr=%b addr=%h strb=%h wdata=%h want 1 1 80001000 3 0000BEEF",
                     lg_breq[c1+1], lg_bwr[c1+1], lg_baddr[c1+1], lg_bstrb[c1+1], lg_bwdat[c1+1]);
        end
        tests_run++;
        if (lg_ddone[c1+3] !== 1'b1 || lg_idone[c1+3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL simul_data_done_c4: got d=%b i=%b want d=1 i=0", lg_ddone[c1+3], lg_idone[c1+3]);
        end
        tests_run++;
        if (lg_breq[c1+5] !== 1'b1 || lg_bwr[c1+5] !== 1'b0 || lg_baddr[c1+5] !== 32'h1FC00040 ||
            lg_bstrb[c1+5] !== 4'hF) begin
            tests_failed++;
            $display("FAIL simul_second_fetch: got req=%b wr=%b addr=%h strb=%h want 1 0 1FC00040 F",
                     lg_breq[c1+5], lg_bwr[c1+5], lg_baddr[c1+5], lg_bstrb[c1+5]);
        end
        tests_run++;
        if (lg_idone[c1+7] !== 1'b1 || lg_irdat[c1+7] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL simul_inst_done_c8: got done=%b rdata=%h want 1 12345678",
                     lg_idone[c1+7], lg_irdat[c1+7]);
        end
    endtask

    task automatic test_contention();
        int         n;
        logic [5:0] order;
        int         dc[6];
        do_reset();
        resp_en = 1'b1; addr_wait = 0; data_wait = 0; resp_rdata = 32'hA5A5A5A5;
        inst_addr = 32'h00000100; data_addr = 32'h00002000; data_wr = 1'b0;
        inst_req = 1'b1; data_req = 1'b1;
        n = 0; order = '0;
        for (int k = 0; k < 80 && n < 6; k++) begin
            @(negedge clk); #1;
            if (data_done || inst_done) begin
                order[5-n] = data_done;
                dc[n] = cyc - 1;
                n++;
            end
        end
        @(posedge clk); #2 inst_req = 1'b0; data_req = 1'b0;
        tests_run++;
        if (n != 6) begin
            tests_failed++;
            $display("FAIL contention_count: got %0d dones want 6", n);
        end
        tests_run++;
        if (order !== 6'b101010) begin
            tests_failed++;
            $display("FAIL contention_order: got %b want 101010 (1=data)", order);
        end
        if (n == 6) begin
            tests_run++;
            if (dc[5] - dc[0] != 20) begin
                tests_failed++;
                $display("FAIL contention_spacing: got %0d cycles want 20", dc[5] - dc[0]);
            end
        end
    endtask

    task automatic test_wait_states();
        int   c1;
        logic seen;
        logic exp_b;
        do_reset();
        resp_en = 1'b1; addr_wait = 3; data_wait = 4; resp_rdata = 32'hCAFEF00D;
        data_wr = 1'b0; data_addr = 32'h00000040; data_wstrb = 4'h0; data_req = 1'b1; c1 = cyc;
        wait_done(1'b1, 30, seen);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL wait_timeout: got no data_done want one"); end
        @(posedge clk); #2 data_req = 1'b0;
        @(negedge clk); #1;
        for (int k = 0; k < 12; k++) begin
            exp_b = (k >= 1 && k <= 4);
            tests_run++;
            if (lg_breq[c1+k] !== exp_b || (exp_b && lg_baddr[c1+k] !== 32'h00000040)) begin
                tests_failed++;
                $display("FAIL wait_bus c%0d: got req=%b addr=%h want req=%b addr=40",
                         k+1, lg_breq[c1+k], lg_baddr[c1+k], exp_b);
            end
            exp_b = (k == 10);
            tests_run++;
            if (lg_ddone[c1+k] !== exp_b || lg_drdat[c1+k] !== (exp_b ? 32'hCAFEF00D : 32'h0)) begin
                tests_failed++;
                $display("FAIL wait_done c%0d: got done=%b rdata=%h want %b", k+1,
                         lg_ddone[c1+k], lg_drdat[c1+k], exp_b);
            end
            exp_b = (k < 10);
            tests_run++;
            if (lg_dbusy[c1+k] !== exp_b) begin
                tests_failed++;
                $display("FAIL wait_busy c%0d: got %b want %b", k+1, lg_dbusy[c1+k], exp_b);
            end
        end
    endtask

    task automatic test_field_stability();
        int c1;
        do_reset();
        resp_en = 1'b0;
        data_wr = 1'b0; data_addr = 32'h00000100; data_req = 1'b1;
        man_addr_ok = 1'b1;
        c1 = cyc;
        @(posedge clk); #2 data_addr = 32'h00000200; man_addr_ok = 1'b0; man_data_ok = 1'b1;
        @(posedge clk); #2 man_data_ok = 1'b0; man_addr_ok = 1'b1;
        @(posedge clk); #2 man_addr_ok = 1'b0;
        @(posedge clk); #2 man_data_ok = 1'b1; man_rdata = 32'h00000055;
        @(posedge clk); #2 man_data_ok = 1'b0; man_rdata = 32'h0;
        @(posedge clk); #2 data_req = 1'b0;
        @(negedge clk); #1;
        tests_run++;
        if (lg_baddr[c1+1] !== 32'h00000100 || lg_baddr[c1+2] !== 32'h00000100) begin
            tests_failed++;
            $display("FAIL stab_addr: got %h %h want 00000100 00000100", lg_baddr[c1+1], lg_baddr[c1+2]);
        end
        tests_run++;
        if ({lg_breq[c1+1], lg_breq[c1+2], lg_breq[c1+3]} !== 3'b110) begin
            tests_failed++;
            $display("FAIL stab_data_ok_in_addr: got bus_req c2..c4=%b%b%b want 110",
                     lg_breq[c1+1], lg_breq[c1+2], lg_breq[c1+3]);
        end
        tests_run++;
        if ({lg_ddone[c1+3], lg_ddone[c1+4], lg_ddone[c1+5]} !== 3'b001 || lg_drdat[c1+5] !== 32'h00000055) begin
            tests_failed++;
            $display("FAIL stab_done: got done c4..c6=%b%b%b rdata=%h want 001 00000055",
                     lg_ddone[c1+3], lg_ddone[c1+4], lg_ddone[c1+5], lg_drdat[c1+5]);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        do_reset();
        resp_en = 1'b1; addr_wait = 0; data_wait = 5; resp_rdata = 32'h00000077;
        inst_addr = 32'h00000300; inst_req = 1'b1;
        @(posedge clk); #2;
        @(posedge clk); #2;
        data_req = 1'b1; data_addr = 32'h00000500; data_wr = 1'b0; data_wstrb = 4'hF;
        @(negedge clk); #1;
        resetn = 1'b0; #1;
        tests_run++;
        if ({bus_req, bus_wr, bus_addr, bus_wstrb, bus_wdata, inst_done, data_done, inst_rdata, data_rdata} !== 136'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got req=%b addr=%h idone=%b ddone=%b want all 0",
                     bus_req, bus_addr, inst_done, data_done);
        end
        tests_run++;
        if ({imem_busy, dmem_busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL midrst_busy: got %b%b want 11", imem_busy, dmem_busy);
        end
        repeat (2) @(posedge clk);
        #2 resetn = 1'b1; data_wait = 0;
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk); #1;
            if (inst_done || data_done) begin seen = 1'b1; break; end
        end
        tests_run++;
        if (!seen || data_done !== 1'b1 || inst_done !== 1'b0 || data_rdata !== 32'h00000077) begin
            tests_failed++;
            $display("FAIL midrst_first_grant: got seen=%b ddone=%b idone=%b rdata=%h want 1 1 0 00000077",
                     seen, data_done, inst_done, data_rdata);
        end
        @(posedge clk); #2 data_req = 1'b0;
        wait_done(1'b0, 20, seen);
        tests_run++;
        if (!seen) begin tests_failed++; $display("FAIL midrst_inst_after: got no inst_done want one"); end
        @(posedge clk); #2 inst_req = 1'b0;
        @(negedge clk); #1;
    endtask

    task automatic test_global_invariants();
        int both, stray;
        both = 0; stray = 0;
        for (int i = 0; i < cyc && i < LOG_N; i++) begin
            if (lg_idone[i] === 1'b1 && lg_ddone[i] === 1'b1) both++;
            if ((lg_idone[i] !== 1'b1 && lg_irdat[i] !== 32'h0) ||
                (lg_ddone[i] !== 1'b1 && lg_drdat[i] !== 32'h0)) stray++;
        end
        tests_run++;
        if (both != 0) begin
            tests_failed++;
            $display("FAIL dones_exclusive: got %0d cycles with both dones want 0", both);
        end
        tests_run++;
        if (stray != 0) begin
            tests_failed++;
            $display("FAIL rdata_gating: got %0d cycles with rdata while done low want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_contention();
        test_wait_states();
        test_field_stability();
        test_reset_mid();
        test_global_invariants();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion within time limit want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
